// File: rtl/time_keeper_bcd.sv
// time_keeper_bcd: BCD hh:mm:ss time-of-day counter for the alarm-clock datapath.
// Runs in 12 h or 24 h format. An adjust mode steps the hour or minute field
// up or down at a programmable rate.
// Optional alarm comparator (al_h, al_m, alarm_hit) enabled by defining ALARM_CMP_EN.
module time_keeper_bcd #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned ADJ_DIV   = 12_500_000,
  parameter int unsigned HOUR_MODE = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adjust,
  input  logic       ent_h,
  input  logic       ent_m,
  input  logic       updown,
`ifdef ALARM_CMP_EN
  input  logic [5:0] al_h,
  input  logic [6:0] al_m,
  output logic       alarm_hit,
`endif
  output logic [1:0] h1,
  output logic [3:0] h2,
  output logic [2:0] m1,
  output logic [3:0] m2,
  output logic [2:0] s1,
  output logic [3:0] s2,
  output logic       pm,
  output logic       sec_tick
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AW = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ADJ_LAST  = AW'(ADJ_DIV - 1);
  localparam bit TWELVE = (HOUR_MODE == 12);

  // Complete displayed time, pm flag included so hour steps update it atomically.
  typedef struct packed {
    logic       pm;
    logic [1:0] h1;
    logic [3:0] h2;
    logic [2:0] m1;
    logic [3:0] m2;
    logic [2:0] s1;
    logic [3:0] s2;
  } tod_t;

  localparam tod_t TOD_RST = '{
    pm: 1'b0,
    h1: TWELVE ? 2'd1 : 2'd0,
    h2: TWELVE ? 4'd2 : 4'd0,
    m1: 3'd0,
    m2: 4'd0,
    s1: 3'd0,
    s2: 4'd0
  };

  logic [TW-1:0] tick_cnt;
  logic [AW-1:0] adj_cnt;
  logic          adjust_q;
  logic          adj_entry_c;
  logic          adj_step_c;
  logic          advance_c;
  tod_t          tod_q;
  tod_t          tod_nxt;

  // Increment a 00..59 BCD field {tens[2:0], units[3:0]}, wrapping 59 -> 00.
  function automatic logic [6:0] inc60(input logic [6:0] v);
    logic [6:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[6:4] = (v[6:4] == 3'd5) ? 3'd0 : v[6:4] + 3'd1;
    end else begin
      r = {v[6:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Decrement a 00..59 BCD field, wrapping 00 -> 59.
  function automatic logic [6:0] dec60(input logic [6:0] v);
    logic [6:0] r;
    if (v[3:0] == 4'd0) begin
      r[3:0] = 4'd9;
      r[6:4] = (v[6:4] == 3'd0) ? 3'd5 : v[6:4] - 3'd1;
    end else begin
      r = {v[6:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  // Step the hour field {pm, tens[1:0], units[3:0]} by one in the configured format.
  function automatic logic [6:0] hour_step(input logic [6:0] v, input logic down);
    logic       p;
    logic [1:0] t;
    logic [3:0] u;
    logic [6:0] r;
    {p, t, u} = v;
    r = v;
    if (TWELVE) begin
      if (!down) begin
        if (t == 2'd1 && u == 4'd2)      r = {p, 2'd0, 4'd1};
        else if (t == 2'd1 && u == 4'd1) r = {~p, 2'd1, 4'd2};
        else if (u == 4'd9)              r = {p, 2'd1, 4'd0};
        else                             r = {p, t, u + 4'd1};
      end else begin
        if (t == 2'd0 && u == 4'd1)      r = {p, 2'd1, 4'd2};
        else if (t == 2'd1 && u == 4'd2) r = {~p, 2'd1, 4'd1};
        else if (u == 4'd0)              r = {p, 2'd0, 4'd9};
        else                             r = {p, t, u - 4'd1};
      end
    end else begin
      if (!down) begin
        if (t == 2'd2 && u == 4'd3)      r = {1'b0, 2'd0, 4'd0};
        else if (u == 4'd9)              r = {1'b0, t + 2'd1, 4'd0};
        else                             r = {1'b0, t, u + 4'd1};
      end else begin
        if (t == 2'd0 && u == 4'd0)      r = {1'b0, 2'd2, 4'd3};
        else if (u == 4'd0)              r = {1'b0, t - 2'd1, 4'd9};
        else                             r = {1'b0, t, u - 4'd1};
      end
    end
    return r;
  endfunction

  // Free-running second prescaler; sec_tick follows the terminal count by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= (tick_cnt == TICK_LAST);
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
    end
  end

  assign adj_entry_c = adjust & ~adjust_q;
  assign adj_step_c  = adjust & adjust_q & (adj_cnt == ADJ_LAST);
  assign advance_c   = ~adjust & sec_tick;

  // Adjust-rate prescaler, restarted on every entry into adjust mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adjust_q <= 1'b0;
      adj_cnt  <= '0;
    end else begin
      adjust_q <= adjust;
      if (!adjust || adj_entry_c || adj_step_c) begin
        adj_cnt <= '0;
      end else begin
        adj_cnt <= adj_cnt + AW'(1);
      end
    end
  end

  // Next time value: real-time advance with carries, or a single adjust step.
  always_comb begin
    tod_nxt = tod_q;
    if (advance_c) begin
      {tod_nxt.s1, tod_nxt.s2} = inc60({tod_q.s1, tod_q.s2});
      if ({tod_q.s1, tod_q.s2} == 7'h59) begin
        {tod_nxt.m1, tod_nxt.m2} = inc60({tod_q.m1, tod_q.m2});
        if ({tod_q.m1, tod_q.m2} == 7'h59) begin
          {tod_nxt.pm, tod_nxt.h1, tod_nxt.h2} =
            hour_step({tod_q.pm, tod_q.h1, tod_q.h2}, 1'b0);
        end
      end
    end else if (adj_step_c) begin
      if (ent_h) begin
        {tod_nxt.pm, tod_nxt.h1, tod_nxt.h2} =
          hour_step({tod_q.pm, tod_q.h1, tod_q.h2}, updown);
      end else if (ent_m) begin
        {tod_nxt.m1, tod_nxt.m2} = updown ? dec60({tod_q.m1, tod_q.m2})
                                          : inc60({tod_q.m1, tod_q.m2});
        {tod_nxt.s1, tod_nxt.s2} = 7'd0;
      end
    end
  end

  // Time-of-day register; every digit updates on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tod_q <= TOD_RST;
    end else begin
      tod_q <= tod_nxt;
    end
  end

`ifdef ALARM_CMP_EN
  // Alarm pulse when a real-time advance lands exactly on al_h:al_m:00.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm_hit <= 1'b0;
    end else begin
      alarm_hit <= advance_c
                 && ({tod_nxt.h1, tod_nxt.h2} == al_h)
                 && ({tod_nxt.m1, tod_nxt.m2} == al_m)
                 && ({tod_nxt.s1, tod_nxt.s2} == 7'd0);
    end
  end
`endif

  assign h1 = tod_q.h1;
  assign h2 = tod_q.h2;
  assign m1 = tod_q.m1;
  assign m2 = tod_q.m2;
  assign s1 = tod_q.s1;
  assign s2 = tod_q.s2;
  assign pm = tod_q.pm;

endmodule

// File: tb/tb_time_keeper_bcd.sv
// tb_time_keeper_bcd: directed bench for time_keeper_bcd.
// Instance a: 24 h, TICK_DIV=1, ADJ_DIV=1. Instance b: 12 h, TICK_DIV=3, ADJ_DIV=4.
module tb_time_keeper_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       a_rst, a_adjust, a_ent_h, a_ent_m, a_updown;
  logic [1:0] a_h1;
  logic [3:0] a_h2, a_m2, a_s2;
  logic [2:0] a_m1, a_s1;
  logic       a_pm, a_sec_tick;
  logic [19:0] a_t;

  logic       b_rst, b_adjust, b_ent_h, b_ent_m, b_updown;
  logic [1:0] b_h1;
  logic [3:0] b_h2, b_m2, b_s2;
  logic [2:0] b_m1, b_s1;
  logic       b_pm, b_sec_tick;
  logic [19:0] b_t;

`ifdef ALARM_CMP_EN
  logic [5:0] a_al_h, b_al_h;
  logic [6:0] a_al_m, b_al_m;
  logic       a_alarm_hit, b_alarm_hit;
`endif

  assign a_t = {a_h1, a_h2, a_m1, a_m2, a_s1, a_s2};
  assign b_t = {b_h1, b_h2, b_m1, b_m2, b_s1, b_s2};

  time_keeper_bcd #(.TICK_DIV(1), .ADJ_DIV(1), .HOUR_MODE(24)) u_a (
    .clk(clk), .rst(a_rst), .adjust(a_adjust), .ent_h(a_ent_h), .ent_m(a_ent_m),
    .updown(a_updown),
`ifdef ALARM_CMP_EN
    .al_h(a_al_h), .al_m(a_al_m), .alarm_hit(a_alarm_hit),
`endif
    .h1(a_h1), .h2(a_h2), .m1(a_m1), .m2(a_m2), .s1(a_s1), .s2(a_s2),
    .pm(a_pm), .sec_tick(a_sec_tick)
  );

  time_keeper_bcd #(.TICK_DIV(3), .ADJ_DIV(4), .HOUR_MODE(12)) u_b (
    .clk(clk), .rst(b_rst), .adjust(b_adjust), .ent_h(b_ent_h), .ent_m(b_ent_m),
    .updown(b_updown),
`ifdef ALARM_CMP_EN
    .al_h(b_al_h), .al_m(b_al_m), .alarm_hit(b_alarm_hit),
`endif
    .h1(b_h1), .h2(b_h2), .m1(b_m1), .m2(b_m2), .s1(b_s1), .s2(b_s2),
    .pm(b_pm), .sec_tick(b_sec_tick)
  );

  function automatic logic [19:0] bcd(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic string fmt(input logic [19:0] t, input logic p);
    return $sformatf("%0d%0d:%0d%0d:%0d%0d pm=%0d",
                     t[19:18], t[17:14], t[13:11], t[10:7], t[6:4], t[3:0], p);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(2);
    n_tests++;
    if (a_t !== bcd(0, 0, 0) || a_pm !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a_time: got %s expected %s", fmt(a_t, a_pm), fmt(bcd(0, 0, 0), 1'b0));
    end
    n_tests++;
    if (a_sec_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a_tick: got %b expected 0", a_sec_tick);
    end
    n_tests++;
    if (b_t !== bcd(12, 0, 0) || b_pm !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b_time: got %s expected %s", fmt(b_t, b_pm), fmt(bcd(12, 0, 0), 1'b0));
    end
    n_tests++;
    if (b_sec_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b_tick: got %b expected 0", b_sec_tick);
    end
  endtask

  // 3601 edges after release: sec_tick from edge 1, first advance at edge 2.
  task automatic test_run_hour();
    int bad = 0;
    a_rst = 1'b1;
    for (int n = 1; n <= 3601; n++) begin
      cyc(1);
      if (a_sec_tick !== 1'b1) bad++;
      if (n == 61) begin
        n_tests++;
        if (a_t !== bcd(0, 1, 0)) begin
          n_fail++;
          $display("FAIL run_minute: got %s expected %s", fmt(a_t, a_pm), fmt(bcd(0, 1, 0), 1'b0));
        end
      end
    end
    n_tests++;
    if (a_t !== bcd(1, 0, 0) || a_pm !== 1'b0) begin
      n_fail++;
      $display("FAIL run_hour: got %s expected %s", fmt(a_t, a_pm), fmt(bcd(1, 0, 0), 1'b0));
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL sec_tick_every_cycle: got %0d low cycles expected 0", bad);
    end
    #2 a_rst = 1'b0;
    #1;
    n_tests++;
    if (a_t !== bcd(0, 0, 0) || a_sec_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %s tick=%b expected %s tick=0",
               fmt(a_t, a_pm), a_sec_tick, fmt(bcd(0, 0, 0), 1'b0));
    end
    cyc(1);
  endtask

  // Preset 23:59:00 by adjust, count to 23:59:58, then wrap to 00:00:00.
  task automatic test_wrap24();
    a_adjust = 1'b1; a_ent_h = 1'b1; a_ent_m = 1'b0; a_updown = 1'b1;
    a_rst = 1'b1;
    cyc(1);
    n_tests++;
    if (a_t !== bcd(0, 0, 0)) begin
      n_fail++;
      $display("FAIL adj_entry_no_step: got %s expected %s", fmt(a_t, a_pm), fmt(bcd(0, 0, 0), 1'b0));
    end
    cyc(1);
    n_tests++;
    if (a_t !== bcd(23, 0, 0)) begin
      n_fail++;
      $display("FAIL hour_down_wrap24: got %s expected %s", fmt(a_t, a_pm), fmt(bcd(23, 0, 0), 1'b0));
    end
    a_ent_h = 1'b0; a_ent_m = 1'b1;
    cyc(1);
    n_tests++;
    if (a_t !== bcd(23, 59, 0)) begin
      n_fail++;
      $display("FAIL min_down_wrap: got %s expected %s", fmt(a_t, a_pm), fmt(bcd(23, 59, 0), 1'b0));
    end
    a_adjust = 1'b0; a_ent_m = 1'b0; a_updown = 1'b0;
    cyc(58);
    n_tests++;
    if (a_t !== bcd(23, 59, 58)) begin
      n_fail++;
      $display("FAIL resume_count: got %s expected %s", fmt(a_t, a_pm), fmt(bcd(23, 59, 58), 1'b0));
    end
    cyc(2);
    n_tests++;
    if (a_t !== bcd(0, 0, 0) || a_pm !== 1'b0) begin
      n_fail++;
      $display("FAIL day_wrap24: got %s expected %s", fmt(a_t, a_pm), fmt(bcd(0, 0, 0), 1'b0));
    end
  endtask

  task automatic test_hour24_up();
    a_rst = 1'b0;
    a_adjust = 1'b1; a_ent_h = 1'b1; a_ent_m = 1'b0; a_updown = 1'b0;
    cyc(1);
    a_rst = 1'b1;
    cyc(1);
    for (int k = 1; k <= 24; k++) begin
      cyc(1);
      n_tests++;
      if (a_t !== bcd(k % 24, 0, 0)) begin
        n_fail++;
        $display("FAIL hour_up24_step%0d: got %s expected %s", k, fmt(a_t, a_pm),
                 fmt(bcd(k % 24, 0, 0), 1'b0));
      end
    end
  endtask

  task automatic test_min_adjust();
    a_rst = 1'b0;
    a_adjust = 1'b0; a_ent_h = 1'b0; a_ent_m = 1'b0; a_updown = 1'b0;
    cyc(1);
    a_rst = 1'b1;
    cyc(38);
    n_tests++;
    if (a_t !== bcd(0, 0, 37)) begin
      n_fail++;
      $display("FAIL preset_37s: got %s expected %s", fmt(a_t, a_pm), fmt(bcd(0, 0, 37), 1'b0));
    end
    a_adjust = 1'b1; a_ent_m = 1'b1; a_updown = 1'b1;
    cyc(1);
    n_tests++;
    if (a_t !== bcd(0, 0, 37)) begin
      n_fail++;
      $display("FAIL adjust_freezes: got %s expected %s", fmt(a_t, a_pm), fmt(bcd(0, 0, 37), 1'b0));
    end
    cyc(1);
    n_tests++;
    if (a_t !== bcd(0, 59, 0)) begin
      n_fail++;
      $display("FAIL min_down_clear_sec: got %s expected %s", fmt(a_t, a_pm), fmt(bcd(0, 59, 0), 1'b0));
    end
    a_ent_h = 1'b1; a_updown = 1'b0;
    cyc(1);
    n_tests++;
    if (a_t !== bcd(1, 59, 0)) begin
      n_fail++;
      $display("FAIL hour_priority: got %s expected %s", fmt(a_t, a_pm), fmt(bcd(1, 59, 0), 1'b0));
    end
    a_updown = 1'b1;
    cyc(1);
    n_tests++;
    if (a_t !== bcd(0, 59, 0)) begin
      n_fail++;
      $display("FAIL hour_down24: got %s expected %s", fmt(a_t, a_pm), fmt(bcd(0, 59, 0), 1'b0));
    end
    a_adjust = 1'b0;
    cyc(1);
    n_tests++;
    if (a_t !== bcd(0, 59, 1)) begin
      n_fail++;
      $display("FAIL updown_ignored_normal: got %s expected %s", fmt(a_t, a_pm), fmt(bcd(0, 59, 1), 1'b0));
    end
    a_ent_h = 1'b0; a_ent_m = 1'b0; a_updown = 1'b0;
  endtask

  // TICK_DIV=3: sec_tick after edges 3,6,9; seconds = (n-1)/3.
  task automatic test_prescaler();
    b_adjust = 1'b0; b_ent_h = 1'b0; b_ent_m = 1'b0; b_updown = 1'b0;
    b_rst = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      cyc(1);
      n_tests++;
      if (b_sec_tick !== 1'((n % 3) == 0) || b_t !== bcd(12, 0, (n - 1) / 3)) begin
        n_fail++;
        $display("FAIL prescaler_n%0d: got tick=%b %s expected tick=%b %s", n, b_sec_tick,
                 fmt(b_t, b_pm), 1'((n % 3) == 0), fmt(bcd(12, 0, (n - 1) / 3), 1'b0));
      end
    end
  endtask

  // ADJ_DIV=4 in 12 h: steps land at edges 5, 9, ... after entry at edge 1.
  task automatic test_adjust_rate();
    int k;
    int hr;
    logic p;
    b_rst = 1'b0;
    b_adjust = 1'b1; b_ent_h = 1'b1; b_ent_m = 1'b0; b_updown = 1'b0;
    cyc(1);
    b_rst = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      cyc(1);
      k  = (n - 1) / 4;
      hr = ((11 + k) % 12) + 1;
      p  = 1'((k / 12) % 2);
      n_tests++;
      if (b_t !== bcd(hr, 0, 0) || b_pm !== p) begin
        n_fail++;
        $display("FAIL hour_up12_n%0d: got %s expected %s", n, fmt(b_t, b_pm), fmt(bcd(hr, 0, 0), p));
      end
    end
    b_updown = 1'b1;
    for (int j = 1; j <= 52; j++) begin
      cyc(1);
      k  = (j + 3) / 4;
      hr = (((11 - k) % 12 + 12) % 12) + 1;
      p  = 1'(k >= 1 && k <= 12);
      n_tests++;
      if (b_t !== bcd(hr, 0, 0) || b_pm !== p) begin
        n_fail++;
        $display("FAIL hour_down12_j%0d: got %s expected %s", j, fmt(b_t, b_pm), fmt(bcd(hr, 0, 0), p));
      end
    end
    b_ent_h = 1'b0; b_ent_m = 1'b1;
    cyc(1);
    n_tests++;
    if (b_t !== bcd(11, 59, 0) || b_pm !== 1'b0) begin
      n_fail++;
      $display("FAIL min_step_rate: got %s expected %s", fmt(b_t, b_pm), fmt(bcd(11, 59, 0), 1'b0));
    end
  endtask

  task automatic wait_sec59(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      cyc(1);
      if (b_s1 == 3'd5 && b_s2 == 4'd9) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: got no :59 within 400 cycles expected :59", name);
    end
  endtask

  task automatic wait_sec_change(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      cyc(1);
      if (!(b_s1 == 3'd5 && b_s2 == 4'd9)) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: got seconds stuck at 59 expected change", name);
    end
  endtask

  task automatic test_wrap12();
    b_adjust = 1'b0; b_ent_m = 1'b0;
    wait_sec59("wrap12_am");
    n_tests++;
    if (b_t !== bcd(11, 59, 59) || b_pm !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_noon: got %s expected %s", fmt(b_t, b_pm), fmt(bcd(11, 59, 59), 1'b0));
    end
    wait_sec_change("wrap12_noon");
    n_tests++;
    if (b_t !== bcd(12, 0, 0) || b_pm !== 1'b1) begin
      n_fail++;
      $display("FAIL noon_pm_toggle: got %s expected %s", fmt(b_t, b_pm), fmt(bcd(12, 0, 0), 1'b1));
    end
    b_adjust = 1'b1; b_ent_m = 1'b1; b_updown = 1'b1;
    cyc(4);
    n_tests++;
    if (b_t !== bcd(12, 0, 0) || b_pm !== 1'b1) begin
      n_fail++;
      $display("FAIL adj_first_step_early: got %s expected %s", fmt(b_t, b_pm), fmt(bcd(12, 0, 0), 1'b1));
    end
    cyc(1);
    n_tests++;
    if (b_t !== bcd(12, 59, 0) || b_pm !== 1'b1) begin
      n_fail++;
      $display("FAIL adj_first_step: got %s expected %s", fmt(b_t, b_pm), fmt(bcd(12, 59, 0), 1'b1));
    end
    b_adjust = 1'b0; b_ent_m = 1'b0; b_updown = 1'b0;
    wait_sec59("wrap12_one");
    n_tests++;
    if (b_t !== bcd(12, 59, 59) || b_pm !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_one: got %s expected %s", fmt(b_t, b_pm), fmt(bcd(12, 59, 59), 1'b1));
    end
    wait_sec_change("wrap12_one_chg");
    n_tests++;
    if (b_t !== bcd(1, 0, 0) || b_pm !== 1'b1) begin
      n_fail++;
      $display("FAIL one_pm_kept: got %s expected %s", fmt(b_t, b_pm), fmt(bcd(1, 0, 0), 1'b1));
    end
  endtask

`ifdef ALARM_CMP_EN
  task automatic test_alarm();
    int hits = 0;
    logic [19:0] at = '0;
    a_al_h = 6'h00; a_al_m = 7'h02;
    a_rst = 1'b0;
    a_adjust = 1'b0; a_ent_h = 1'b0; a_ent_m = 1'b0; a_updown = 1'b0;
    cyc(1);
    n_tests++;
    if (a_alarm_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL alarm_reset: got %b expected 0", a_alarm_hit);
    end
    a_rst = 1'b1;
    for (int n = 1; n <= 130; n++) begin
      cyc(1);
      if (a_alarm_hit === 1'b1) begin
        hits++;
        at = a_t;
      end
    end
    n_tests++;
    if (hits != 1 || at !== bcd(0, 2, 0)) begin
      n_fail++;
      $display("FAIL alarm_once: got %0d hits at %s expected 1 at %s", hits, fmt(at, 1'b0),
               fmt(bcd(0, 2, 0), 1'b0));
    end
    a_rst = 1'b0;
    a_adjust = 1'b1; a_ent_m = 1'b1;
    cyc(1);
    a_rst = 1'b1;
    hits = 0;
    for (int n = 1; n <= 6; n++) begin
      cyc(1);
      if (n == 3) a_adjust = 1'b0;
      if (a_alarm_hit === 1'b1) hits++;
    end
    n_tests++;
    if (hits != 0) begin
      n_fail++;
      $display("FAIL alarm_adjust_silent: got %0d hits expected 0", hits);
    end
    a_ent_m = 1'b0;
  endtask
`endif

  initial begin
    a_rst = 1'b0; a_adjust = 1'b0; a_ent_h = 1'b0; a_ent_m = 1'b0; a_updown = 1'b0;
    b_rst = 1'b0; b_adjust = 1'b0; b_ent_h = 1'b0; b_ent_m = 1'b0; b_updown = 1'b0;
`ifdef ALARM_CMP_EN
    a_al_h = 6'h00; a_al_m = 7'h02;
    b_al_h = 6'h00; b_al_m = 7'h00;
`endif
    test_reset();
    test_run_hour();
    test_wrap24();
    test_hour24_up();
    test_min_adjust();
    test_prescaler();
    test_adjust_rate();
    test_wrap12();
`ifdef ALARM_CMP_EN
    test_alarm();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
